// File: rtl/center_of_mass.sv
// Centroid of thresholded-mask pixels: accumulate x/y sums and a pixel count over a frame, then divide.
// Latency: tabulate_in sampled at edge k -> valid_out high after edge k+SUM_BITS+1.
// Backpressure: none; pixels and tabulate pulses arriving while busy_out=1 are dropped.
// Optional COM_MIN_COUNT_EN: frames with fewer than MIN_COUNT pixels are treated as empty.
module center_of_mass #(
   parameter int H_BITS    = 11,
   parameter int V_BITS    = 10,
   parameter int SUM_BITS  = 32,
   parameter int CNT_BITS  = 21,
   parameter int MIN_COUNT = 64
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [H_BITS-1:0] x_in,
   input  logic [V_BITS-1:0] y_in,
   input  logic              valid_in,
   input  logic              tabulate_in,
   output logic [H_BITS-1:0] x_out,
   output logic [V_BITS-1:0] y_out,
   output logic              valid_out,
   output logic              busy_out
);

   localparam int IT_BITS = $clog2(SUM_BITS);

   // Smallest frame pixel count that yields a centroid; an empty frame never divides.
`ifdef COM_MIN_COUNT_EN
   localparam logic [CNT_BITS-1:0] THRESH = CNT_BITS'(MIN_COUNT);
`else
   localparam logic [CNT_BITS-1:0] THRESH = CNT_BITS'(1);
`endif

   typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

   state_t              state_q, state_d;
   logic [SUM_BITS-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [SUM_BITS-1:0] quo_x_q, quo_x_d, quo_y_q, quo_y_d;
   logic [CNT_BITS-1:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
   logic [CNT_BITS-1:0] div_q, div_d;
   logic [IT_BITS-1:0]  it_q, it_d;
   logic [H_BITS-1:0]   x_q, x_d;
   logic [V_BITS-1:0]   y_q, y_d;
   logic                vld_q, vld_d;

   // Sums/count including the current pixel; count sticks at all-ones instead of wrapping.
   logic [SUM_BITS-1:0] fin_x, fin_y;
   logic [CNT_BITS-1:0] fin_cnt;

   // Restoring divider step: shift the next dividend bit into the remainder, subtract if it fits.
   logic [CNT_BITS:0]   rsh_x, rsh_y;
   logic                ge_x, ge_y;

   // Pixel accumulation terms shared by ACCUM and DONE.
   always_comb begin
      fin_x   = sum_x_q;
      fin_y   = sum_y_q;
      fin_cnt = cnt_q;
      if (valid_in) begin
         fin_x = sum_x_q + {{(SUM_BITS-H_BITS){1'b0}}, x_in};
         fin_y = sum_y_q + {{(SUM_BITS-V_BITS){1'b0}}, y_in};
         if (cnt_q != '1) begin
            fin_cnt = cnt_q + 1'b1;
         end
      end
   end

   assign rsh_x = {rem_x_q, quo_x_q[SUM_BITS-1]};
   assign rsh_y = {rem_y_q, quo_y_q[SUM_BITS-1]};
   assign ge_x  = (rsh_x >= {1'b0, div_q});
   assign ge_y  = (rsh_y >= {1'b0, div_q});

   // Next-state and datapath control for the accumulate / divide / publish sequence.
   always_comb begin
      state_d = state_q;
      sum_x_d = sum_x_q;
      sum_y_d = sum_y_q;
      cnt_d   = cnt_q;
      quo_x_d = quo_x_q;
      quo_y_d = quo_y_q;
      rem_x_d = rem_x_q;
      rem_y_d = rem_y_q;
      div_d   = div_q;
      it_d    = it_q;
      x_d     = x_q;
      y_d     = y_q;
      vld_d   = 1'b0;
      case (state_q)
         ACCUM: begin
            sum_x_d = fin_x;
            sum_y_d = fin_y;
            cnt_d   = fin_cnt;
            if (tabulate_in) begin
               // Hand the final totals to the divider and start the next frame from zero.
               sum_x_d = '0;
               sum_y_d = '0;
               cnt_d   = '0;
               quo_x_d = fin_x;
               quo_y_d = fin_y;
               rem_x_d = '0;
               rem_y_d = '0;
               div_d   = fin_cnt;
               it_d    = '0;
               if (fin_cnt >= THRESH) begin
                  state_d = DIVIDE;
               end
            end
         end
         DIVIDE: begin
            // The dividend register doubles as the quotient register: one bit shifts out, one in.
            quo_x_d = {quo_x_q[SUM_BITS-2:0], ge_x};
            quo_y_d = {quo_y_q[SUM_BITS-2:0], ge_y};
            rem_x_d = ge_x ? CNT_BITS'(rsh_x - {1'b0, div_q}) : rsh_x[CNT_BITS-1:0];
            rem_y_d = ge_y ? CNT_BITS'(rsh_y - {1'b0, div_q}) : rsh_y[CNT_BITS-1:0];
            if (it_q == IT_BITS'(SUM_BITS-1)) begin
               state_d = DONE;
            end else begin
               it_d = it_q + 1'b1;
            end
         end
         DONE: begin
            // Pixels already belong to the next frame; a tabulate here is ignored.
            sum_x_d = fin_x;
            sum_y_d = fin_y;
            cnt_d   = fin_cnt;
            x_d     = quo_x_q[H_BITS-1:0];
            y_d     = quo_y_q[V_BITS-1:0];
            vld_d   = 1'b1;
            state_d = ACCUM;
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // State registers with synchronous reset; reset mid-divide simply abandons the divide.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ACCUM;
         sum_x_q <= '0;
         sum_y_q <= '0;
         cnt_q   <= '0;
         quo_x_q <= '0;
         quo_y_q <= '0;
         rem_x_q <= '0;
         rem_y_q <= '0;
         div_q   <= '0;
         it_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_x_q <= sum_x_d;
         sum_y_q <= sum_y_d;
         cnt_q   <= cnt_d;
         quo_x_q <= quo_x_d;
         quo_y_q <= quo_y_d;
         rem_x_q <= rem_x_d;
         rem_y_q <= rem_y_d;
         div_q   <= div_d;
         it_q    <= it_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vld_q   <= vld_d;
      end
   end

   assign x_out     = x_q;
   assign y_out     = y_q;
   assign valid_out = vld_q;
   assign busy_out  = (state_q == DIVIDE);

endmodule

// File: tb/tb_center_of_mass.sv
// Bench for center_of_mass: directed frames plus randomized frames against an arithmetic centroid model.
// Latency: expects valid_out 34 samples after the tabulate edge and busy_out for 32 cycles.
// Backpressure: injects pixels/tabulate during the divide and expects them to be dropped.
module tb_center_of_mass;

   localparam int H_BITS = 11;
   localparam int V_BITS = 10;
`ifdef COM_MIN_COUNT_EN
   localparam int THRESH = 64;
`else
   localparam int THRESH = 1;
`endif

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b1;
   logic [H_BITS-1:0] x_in = '0;
   logic [V_BITS-1:0] y_in = '0;
   logic              valid_in = 1'b0;
   logic              tabulate_in = 1'b0;
   logic [H_BITS-1:0] x_out;
   logic [V_BITS-1:0] y_out;
   logic              valid_out;
   logic              busy_out;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: last published centroid and the pixels of the frame being built.
   int model_x = 0;
   int model_y = 0;
   int qx[$];
   int qy[$];

   center_of_mass dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .x_in        (x_in),
      .y_in        (y_in),
      .valid_in    (valid_in),
      .tabulate_in (tabulate_in),
      .x_out       (x_out),
      .y_out       (y_out),
      .valid_out   (valid_out),
      .busy_out    (busy_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic add_px(input int x, input int y);
      qx.push_back(x);
      qy.push_back(y);
   endtask

   // Play the queued pixels, pulse tabulate, then watch the outputs for a bounded window.
   task automatic run_frame(input string tag, input bit last_on_tab, input bit inject);
      int     n;
      int     n_lead;
      longint sx, sy;
      bit     exp_v;
      int     busy_n, v_n, v_at;
      n = qx.size();
      sx = 0;
      sy = 0;
      foreach (qx[i]) begin
         sx += qx[i];
         sy += qy[i];
      end
      n_lead = (last_on_tab && n > 0) ? n - 1 : n;
      for (int i = 0; i < n_lead; i++) begin
         x_in = H_BITS'(qx[i]);
         y_in = V_BITS'(qy[i]);
         valid_in = 1'b1;
         tick();
      end
      valid_in = 1'b0;
      if (n_lead != n) begin
         x_in = H_BITS'(qx[n-1]);
         y_in = V_BITS'(qy[n-1]);
         valid_in = 1'b1;
      end
      tabulate_in = 1'b1;
      tick();
      tabulate_in = 1'b0;
      valid_in = 1'b0;
      exp_v = (n >= THRESH);
      if (exp_v) begin
         model_x = int'(sx / n);
         model_y = int'(sy / n);
      end
      busy_n = 0;
      v_n = 0;
      v_at = 0;
      for (int c = 1; c <= 45; c++) begin
         if (busy_out) busy_n++;
         if (valid_out) begin
            v_n++;
            v_at = c;
         end
         if (inject && c == 5) begin
            x_in = 11'd500;
            y_in = 10'd500;
            valid_in = 1'b1;
            tabulate_in = 1'b1;
         end else if (inject && c == 6) begin
            valid_in = 1'b0;
            tabulate_in = 1'b0;
         end
         tick();
      end
      chk({tag, ".valid_pulses"}, v_n, exp_v ? 1 : 0);
      chk({tag, ".busy_cycles"}, busy_n, exp_v ? 32 : 0);
      if (exp_v) chk({tag, ".latency"}, v_at, 34);
      chk({tag, ".x"}, x_out, model_x);
      chk({tag, ".y"}, y_out, model_y);
      qx.delete();
      qy.delete();
   endtask

   initial begin
      tick();
      tick();
      rst_in = 1'b0;

      // Idle after reset: everything stays at zero.
      for (int c = 0; c < 20; c++) begin
         chk("idle.x", x_out, 0);
         chk("idle.y", y_out, 0);
         chk("idle.valid", valid_out, 0);
         chk("idle.busy", busy_out, 0);
         tick();
      end

      // Square of four pixels and the 10.5 truncation case (only meaningful without a size floor).
      add_px(100, 50); add_px(102, 50); add_px(100, 52); add_px(102, 52);
      run_frame("square", 1'b0, 1'b0);
      add_px(10, 0); add_px(11, 0);
      run_frame("trunc", 1'b0, 1'b0);

      // Empty frame: no pulse, previous centroid held.
      run_frame("empty", 1'b0, 1'b0);

      // Big frame so there is a real centroid, with pixel+tabulate injected mid-divide.
      for (int i = 0; i < 70; i++) add_px(200 + (i % 7), 300 + (i % 5));
      run_frame("inject", 1'b0, 1'b1);
      add_px(7, 9);
      run_frame("single", 1'b0, 1'b0);

      // Size-floor boundary: 63 versus 64 pixels.
      for (int i = 0; i < 63; i++) add_px(1000 + i, 20);
      run_frame("px63", 1'b0, 1'b0);
      for (int i = 0; i < 64; i++) add_px(40, 900 - i);
      run_frame("px64", 1'b1, 1'b0);

      // Randomized frames; last pixel sometimes arrives in the tabulate cycle.
      for (int f = 0; f < 10; f++) begin
         int n;
         n = (f % 3 == 0) ? int'($urandom_range(60, 80)) : int'($urandom_range(0, 20));
         for (int i = 0; i < n; i++) add_px(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
         run_frame("rand", 1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset ten cycles into a divide: aborted, outputs return to zero.
      for (int i = 0; i < 70; i++) add_px(333, 444);
      foreach (qx[i]) begin
         x_in = H_BITS'(qx[i]);
         y_in = V_BITS'(qy[i]);
         valid_in = 1'b1;
         tick();
      end
      valid_in = 1'b0;
      qx.delete();
      qy.delete();
      tabulate_in = 1'b1;
      tick();
      tabulate_in = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      chk("rst.busy_before", busy_out, 1);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk("rst.busy_after", busy_out, 0);
      begin
         int v_n;
         v_n = 0;
         for (int c = 0; c < 40; c++) begin
            if (valid_out) v_n++;
            tick();
         end
         chk("rst.valid_pulses", v_n, 0);
      end
      model_x = 0;
      model_y = 0;
      chk("rst.x", x_out, model_x);
      chk("rst.y", y_out, model_y);
      add_px(7, 9);
      run_frame("post_rst", 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
